voice_allocator: RTL and testbench

Schedules incoming note events onto the shared pool of wave-generator voices: note-on events get a voice, and note-off events release it. Decides which oscillator slot of the synth configuration each MIDI note occupies, retriggers voices and steals the oldest voice when the pool is full. Sits between the MIDI/SPI command decode and the per-voice configuration registers, issuing one single-cycle voice write per event.

---
 rtl/voice_allocator.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: schedules note-on/note-off events onto a pool of N_VOICES voices.
// Optional build macro VOICE_STEAL_EN: a note-on into a full pool steals the oldest voice.
module voice_allocator #(
    parameter int unsigned N_VOICES = 8,
    parameter int unsigned AGE_W    = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic                        ev_on,
    input  logic [6:0]                  ev_note,
    input  logic [6:0]                  ev_velocity,
    input  logic                        all_off,
    output logic                        voice_we,
    output logic [$clog2(N_VOICES)-1:0] voice_idx,
    output logic [6:0]                  voice_note,
    output logic [6:0]                  voice_velocity,
    output logic                        voice_gate,
    output logic                        voice_retrig,
    output logic [N_VOICES-1:0]         active_mask,
    output logic                        stolen,
    output logic                        dropped
);

    localparam int unsigned      IDX_W    = $clog2(N_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StScan, StCommit, StFlush} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             flush_pend_q, flush_pend_d;
    logic             accept;

    logic [N_VOICES-1:0] active_q, active_d;
    logic [6:0]          note_q [N_VOICES];
    logic [6:0]          note_d [N_VOICES];
    logic [6:0]          vel_q  [N_VOICES];
    logic [6:0]          vel_d  [N_VOICES];
    logic [AGE_W-1:0]    age_q  [N_VOICES];
    logic [AGE_W-1:0]    age_d  [N_VOICES];

    logic       ev_on_q;
    logic [6:0] ev_note_q;
    logic [6:0] ev_vel_q;

    // *_q: result over voices already visited; *_c: including the voice under the pointer
    logic             match_vld_q, match_vld_c;
    logic [IDX_W-1:0] match_idx_q, match_idx_c;
    logic             free_vld_q, free_vld_c;
    logic [IDX_W-1:0] free_idx_q, free_idx_c;
`ifdef VOICE_STEAL_EN
    logic             old_vld_q, old_vld_c;
    logic [IDX_W-1:0] old_idx_q, old_idx_c;
    logic [AGE_W-1:0] old_age_q, old_age_c;
    logic             stolen_q, stolen_d;
`endif

    logic             we_q, we_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [6:0]       onote_q, onote_d;
    logic [6:0]       ovel_q, ovel_d;
    logic             gate_q, gate_d;
    logic             retrig_q, retrig_d;
    logic             dropped_q, dropped_d;

    logic             tgt_vld;
    logic [IDX_W-1:0] tgt_idx;

    assign ev_ready = (state_q == StIdle) && !flush_pend_q && !all_off;
    assign accept   = ev_valid && ev_ready;

    always_comb begin
        match_vld_c = match_vld_q;
        match_idx_c = match_idx_q;
        free_vld_c  = free_vld_q;
        free_idx_c  = free_idx_q;
        if (active_q[ptr_q] && (note_q[ptr_q] == ev_note_q) && !match_vld_q) begin
            match_vld_c = 1'b1;
            match_idx_c = ptr_q;
        end
        if (!active_q[ptr_q] && !free_vld_q) begin
            free_vld_c = 1'b1;
            free_idx_c = ptr_q;
        end
`ifdef VOICE_STEAL_EN
        old_vld_c = old_vld_q;
        old_idx_c = old_idx_q;
        old_age_c = old_age_q;
        // Strict compare keeps the lowest index on equal ages
        if (active_q[ptr_q] && (!old_vld_q || (age_q[ptr_q] > old_age_q))) begin
            old_vld_c = 1'b1;
            old_idx_c = ptr_q;
            old_age_c = age_q[ptr_q];
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        flush_pend_d = flush_pend_q || all_off;
        active_d     = active_q;
        note_d       = note_q;
        vel_d        = vel_q;
        age_d        = age_q;
        we_d         = 1'b0;
        idx_d        = idx_q;
        onote_d      = onote_q;
        ovel_d       = ovel_q;
        gate_d       = gate_q;
        retrig_d     = retrig_q;
        dropped_d    = 1'b0;
`ifdef VOICE_STEAL_EN
        stolen_d     = 1'b0;
`endif
        tgt_vld      = 1'b0;
        tgt_idx      = '0;

        unique case (state_q)
            StIdle: begin
                if (flush_pend_q || all_off) begin
                    // An all_off seen in this cycle is served by the flush being entered
                    state_d      = StFlush;
                    ptr_d        = '0;
                    flush_pend_d = 1'b0;
                end else if (ev_valid) begin
                    state_d = StScan;
                    ptr_d   = '0;
                end
            end
            StScan: begin
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == LAST_IDX) begin
                    state_d = StCommit;
                    if (ev_on_q) begin
                        if (match_vld_c) begin
                            tgt_vld = 1'b1;
                            tgt_idx = match_idx_c;
                        end else if (free_vld_c) begin
                            tgt_vld = 1'b1;
                            tgt_idx = free_idx_c;
                        end
`ifdef VOICE_STEAL_EN
                        else begin
                            tgt_vld  = 1'b1;
                            tgt_idx  = old_idx_c;
                            stolen_d = 1'b1;
                        end
`else
                        else begin
                            dropped_d = 1'b1;
                        end
`endif
                        if (tgt_vld) begin
                            for (int unsigned i = 0; i < N_VOICES; i++) begin
                                if (active_q[i] && (age_q[i] != AGE_MAX)) begin
                                    age_d[i] = age_q[i] + AGE_W'(1);
                                end
                            end
                            active_d[tgt_idx] = 1'b1;
                            note_d[tgt_idx]   = ev_note_q;
                            vel_d[tgt_idx]    = ev_vel_q;
                            age_d[tgt_idx]    = '0;
                            we_d              = 1'b1;
                            idx_d             = tgt_idx;
                            onote_d           = ev_note_q;
                            ovel_d            = ev_vel_q;
                            gate_d            = 1'b1;
                            retrig_d          = 1'b1;
                        end
                    end else if (match_vld_c) begin
                        active_d[match_idx_c] = 1'b0;
                        we_d                  = 1'b1;
                        idx_d                 = match_idx_c;
                        onote_d               = note_q[match_idx_c];
                        ovel_d                = vel_q[match_idx_c];
                        gate_d                = 1'b0;
                        retrig_d              = 1'b0;
                    end
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            StFlush: begin
                if (active_q[ptr_q]) begin
                    we_d     = 1'b1;
                    idx_d    = ptr_q;
                    onote_d  = note_q[ptr_q];
                    ovel_d   = vel_q[ptr_q];
                    gate_d   = 1'b0;
                    retrig_d = 1'b0;
                end
                active_d[ptr_q] = 1'b0;
                age_d[ptr_q]    = '0;
                ptr_d           = ptr_q + IDX_W'(1);
                if (ptr_q == LAST_IDX) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            flush_pend_q <= 1'b0;
            active_q     <= '0;
            for (int unsigned i = 0; i < N_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            flush_pend_q <= flush_pend_d;
            active_q     <= active_d;
            note_q       <= note_d;
            vel_q        <= vel_d;
            age_q        <= age_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            ev_vel_q    <= '0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
        end else if (accept) begin
            // Velocity 0 on a note-on is a note-off
            ev_on_q     <= ev_on && (ev_velocity != 7'd0);
            ev_note_q   <= ev_note;
            ev_vel_q    <= ev_velocity;
            match_vld_q <= 1'b0;
            free_vld_q  <= 1'b0;
        end else if (state_q == StScan) begin
            match_vld_q <= match_vld_c;
            match_idx_q <= match_idx_c;
            free_vld_q  <= free_vld_c;
            free_idx_q  <= free_idx_c;
        end
    end

`ifdef VOICE_STEAL_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            old_vld_q <= 1'b0;
            old_idx_q <= '0;
            old_age_q <= '0;
            stolen_q  <= 1'b0;
        end else begin
            stolen_q <= stolen_d;
            if (accept) begin
                old_vld_q <= 1'b0;
            end else if (state_q == StScan) begin
                old_vld_q <= old_vld_c;
                old_idx_q <= old_idx_c;
                old_age_q <= old_age_c;
            end
        end
    end

    assign stolen = stolen_q;
`else
    assign stolen = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q      <= 1'b0;
            idx_q     <= '0;
            onote_q   <= '0;
            ovel_q    <= '0;
            gate_q    <= 1'b0;
            retrig_q  <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            we_q      <= we_d;
            idx_q     <= idx_d;
            onote_q   <= onote_d;
            ovel_q    <= ovel_d;
            gate_q    <= gate_d;
            retrig_q  <= retrig_d;
            dropped_q <= dropped_d;
        end
    end

    assign voice_we       = we_q;
    assign voice_idx      = idx_q;
    assign voice_note     = onote_q;
    assign voice_velocity = ovel_q;
    assign voice_gate     = gate_q;
    assign voice_retrig   = retrig_q;
    assign dropped        = dropped_q;
    assign active_mask    = active_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed and randomized checks of voice_allocator with N_VOICES=4.
// Expected writes come from an array model of the allocation rules kept in this bench.
`timescale 1ns/1ps
module tb_voice_allocator;
    localparam int N       = 4;
    localparam int IW      = 2;
    localparam int AW      = 3;
    localparam int AGE_SAT = 7;
`ifdef VOICE_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          ev_valid = 1'b0;
    logic          ev_ready;
    logic          ev_on = 1'b0;
    logic [6:0]    ev_note = '0;
    logic [6:0]    ev_velocity = '0;
    logic          all_off = 1'b0;
    logic          voice_we;
    logic [IW-1:0] voice_idx;
    logic [6:0]    voice_note;
    logic [6:0]    voice_velocity;
    logic          voice_gate;
    logic          voice_retrig;
    logic [N-1:0]  active_mask;
    logic          stolen;
    logic          dropped;

    int checks = 0;
    int failures = 0;

    int m_active[N];
    int m_note[N];
    int m_vel[N];
    int m_age[N];

    bit e_we, e_gate, e_retrig, e_stolen, e_dropped;
    int e_idx, e_note, e_vel;

    int            c_nwe;
    logic [IW-1:0] c_idx;
    logic [6:0]    c_note, c_vel;
    logic          c_gate, c_retrig, c_stolen, c_dropped, c_rdy_commit, c_rdy_after;
    logic [N-1:0]  c_mask;

    voice_allocator #(.N_VOICES(N), .AGE_W(AW)) dut (
        .clk(clk), .rstn(rstn), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
        .ev_note(ev_note), .ev_velocity(ev_velocity), .all_off(all_off), .voice_we(voice_we),
        .voice_idx(voice_idx), .voice_note(voice_note), .voice_velocity(voice_velocity),
        .voice_gate(voice_gate), .voice_retrig(voice_retrig), .active_mask(active_mask),
        .stolen(stolen), .dropped(dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = (m_active[i] != 0);
        return m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_active[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
    endtask

    // Rules: match > free > oldest (largest age, lowest index on ties); vel 0 means off
    task automatic model_event(input bit on, input int nt, input int vl);
        int match, free, old, tgt;
        match = -1; free = -1; old = -1; tgt = -1;
        e_we = 0; e_idx = 0; e_note = 0; e_vel = 0; e_gate = 0; e_retrig = 0;
        e_stolen = 0; e_dropped = 0;
        for (int i = 0; i < N; i++) begin
            if (m_active[i] != 0 && m_note[i] == nt && match < 0) match = i;
            if (m_active[i] == 0 && free < 0) free = i;
            if (m_active[i] != 0 && (old < 0 || m_age[i] > m_age[old])) old = i;
        end
        if (on && vl != 0) begin
            if (match >= 0) tgt = match;
            else if (free >= 0) tgt = free;
            else if (STEAL_EN) begin tgt = old; e_stolen = 1; end
            else e_dropped = 1;
            if (tgt >= 0) begin
                for (int i = 0; i < N; i++)
                    if (m_active[i] != 0 && i != tgt && m_age[i] < AGE_SAT) m_age[i]++;
                m_active[tgt] = 1; m_note[tgt] = nt; m_vel[tgt] = vl; m_age[tgt] = 0;
                e_we = 1; e_idx = tgt; e_note = nt; e_vel = vl; e_gate = 1; e_retrig = 1;
            end
        end else if (match >= 0) begin
            e_we = 1; e_idx = match; e_note = m_note[match]; e_vel = m_vel[match];
            m_active[match] = 0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0; ev_valid = 1'b0; all_off = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_clear();
    endtask

    // Offers one event from a negedge and captures the commit cycle (k+N+1) and k+N+2
    task automatic run_event(input bit on, input int nt, input int vl);
        int waitc;
        ev_valid = 1'b1; ev_on = on; ev_note = 7'(nt); ev_velocity = 7'(vl);
        waitc = 0;
        while (!ev_ready && waitc < 60) begin @(negedge clk); waitc++; end
        if (!ev_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: ev_ready=%b required 1 within 60 cycles", ev_ready);
            ev_valid = 1'b0;
            $fatal(1, "no acceptance");
        end
        @(negedge clk);
        ev_valid = 1'b0;
        ev_on = 1'($urandom); ev_note = 7'($urandom); ev_velocity = 7'($urandom);
        c_nwe = 0;
        for (int s = 1; s <= N + 2; s++) begin
            if (s > 1) @(negedge clk);
            if (voice_we) c_nwe++;
            if (s == N + 1) begin
                c_idx = voice_idx; c_note = voice_note; c_vel = voice_velocity;
                c_gate = voice_gate; c_retrig = voice_retrig; c_stolen = stolen;
                c_dropped = dropped; c_mask = active_mask; c_rdy_commit = ev_ready;
            end
            if (s == N + 2) c_rdy_after = ev_ready;
        end
        model_event(on, nt, vl);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({voice_we, voice_idx, voice_note, voice_velocity, voice_gate, voice_retrig,
             stolen, dropped} !== '0)
            begin failures++; $display("FAIL reset_outputs: we=%b idx=%0d note=%0d vel=%0d gate=%b retrig=%b stolen=%b dropped=%b required all 0", voice_we, voice_idx, voice_note, voice_velocity, voice_gate, voice_retrig, stolen, dropped); end
        checks++;
        if (active_mask !== 4'b0000) begin failures++; $display("FAIL reset_mask: got %b required 0000", active_mask); end
        checks++;
        if (ev_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", ev_ready); end
        all_off = 1'b1;
        #1;
        checks++;
        if (ev_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_all_off: got %b required 0", ev_ready); end
        all_off = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_clear();
    endtask

    task automatic test_first_note();
        apply_reset();
        run_event(1, 60, 100);
        checks++; if (c_nwe !== 1) begin failures++; $display("FAIL first_we_count: got %0d required 1", c_nwe); end
        checks++;
        if ({c_idx, c_note, c_vel, c_gate, c_retrig} !== {2'd0, 7'd60, 7'd100, 1'b1, 1'b1})
            begin failures++; $display("FAIL first_write: idx=%0d note=%0d vel=%0d gate=%b retrig=%b required 0/60/100/1/1", c_idx, c_note, c_vel, c_gate, c_retrig); end
        checks++; if (c_mask !== 4'b0001) begin failures++; $display("FAIL first_mask: got %b required 0001", c_mask); end
        checks++;
        if ({c_rdy_commit, c_rdy_after} !== 2'b01)
            begin failures++; $display("FAIL first_ready: commit=%b after=%b required 0 then 1", c_rdy_commit, c_rdy_after); end
    endtask

    task automatic test_pool_full();
        apply_reset();
        for (int i = 0; i < N; i++) begin
            run_event(1, 60 + 2 * i + (i == 3 ? -1 : 0), 100);
            checks++;
            if (c_idx !== IW'(i)) begin failures++; $display("FAIL fill_idx%0d: got %0d required %0d", i, c_idx, i); end
        end
        run_event(1, 67, 100);
`ifdef VOICE_STEAL_EN
        checks++;
        if ({c_nwe == 1, c_idx, c_note, c_stolen, c_dropped} !== {1'b1, 2'd0, 7'd67, 1'b1, 1'b0})
            begin failures++; $display("FAIL steal: nwe=%0d idx=%0d note=%0d stolen=%b dropped=%b required 1/0/67/1/0", c_nwe, c_idx, c_note, c_stolen, c_dropped); end
        run_event(1, 69, 90);
        checks++;
        if ({c_idx, c_stolen} !== {2'd1, 1'b1}) begin failures++; $display("FAIL steal_next: idx=%0d stolen=%b required 1/1", c_idx, c_stolen); end
`else
        checks++;
        if ({c_nwe == 1, c_stolen, c_dropped} !== {1'b0, 1'b0, 1'b1})
            begin failures++; $display("FAIL drop: nwe=%0d stolen=%b dropped=%b required 0/0/1", c_nwe, c_stolen, c_dropped); end
`endif
        checks++; if (c_mask !== 4'b1111) begin failures++; $display("FAIL full_mask: got %b required 1111", c_mask); end
    endtask

    task automatic test_retrigger();
        apply_reset();
        run_event(1, 60, 100);
        run_event(1, 60, 50);
        checks++;
        if ({c_nwe == 1, c_idx, c_vel, c_gate, c_retrig, c_stolen, c_mask} !== {1'b1, 2'd0, 7'd50, 1'b1, 1'b1, 1'b0, 4'b0001})
            begin failures++; $display("FAIL retrigger: nwe=%0d idx=%0d vel=%0d gate=%b retrig=%b stolen=%b mask=%b required 1/0/50/1/1/0/0001", c_nwe, c_idx, c_vel, c_gate, c_retrig, c_stolen, c_mask); end
    endtask

    task automatic test_note_off();
        apply_reset();
        run_event(1, 60, 100);
        run_event(0, 60, 33);
        checks++;
        if ({c_nwe == 1, c_idx, c_note, c_vel, c_gate, c_retrig, c_mask} !== {1'b1, 2'd0, 7'd60, 7'd100, 1'b0, 1'b0, 4'b0000})
            begin failures++; $display("FAIL note_off: nwe=%0d idx=%0d note=%0d vel=%0d gate=%b retrig=%b mask=%b required 1/0/60/100/0/0/0000", c_nwe, c_idx, c_note, c_vel, c_gate, c_retrig, c_mask); end
        run_event(0, 61, 0);
        checks++;
        if ({c_nwe == 0, c_dropped} !== 2'b10) begin failures++; $display("FAIL off_nomatch: nwe=%0d dropped=%b required 0/0", c_nwe, c_dropped); end
    endtask

    task automatic test_vel_zero();
        apply_reset();
        run_event(1, 60, 100);
        run_event(1, 62, 0);
        checks++;
        if ({c_nwe == 0, c_dropped, c_mask} !== {1'b1, 1'b0, 4'b0001})
            begin failures++; $display("FAIL vel_zero: nwe=%0d dropped=%b mask=%b required 0/0/0001", c_nwe, c_dropped, c_mask); end
        run_event(1, 62, 90);
        checks++;
        if ({c_idx, c_vel, c_mask} !== {2'd1, 7'd90, 4'b0011})
            begin failures++; $display("FAIL vel_zero_next: idx=%0d vel=%0d mask=%b required 1/90/0011", c_idx, c_vel, c_mask); end
    endtask

    task automatic test_all_off_scan();
        bit exp_we;
        apply_reset();
        run_event(1, 60, 100);
        run_event(1, 62, 100);
        run_event(1, 64, 100);
        run_event(0, 62, 0);
        checks++; if (active_mask !== 4'b0101) begin failures++; $display("FAIL pre_flush_mask: got %b required 0101", active_mask); end
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60; ev_velocity = 7'd77;
        for (int s = 1; s <= 11; s++) begin
            @(negedge clk);
            exp_we = (s == 5 || s == 8 || s == 10);
            checks++;
            if (ev_ready !== (s == 11)) begin failures++; $display("FAIL scanflush_ready_c%0d: got %b required %b", s, ev_ready, s == 11); end
            checks++;
            if (voice_we !== exp_we) begin failures++; $display("FAIL scanflush_we_c%0d: got %b required %b", s, voice_we, exp_we); end
            if (s == 5) begin
                checks++;
                if ({voice_idx, voice_velocity, voice_gate, voice_retrig, active_mask} !== {2'd0, 7'd77, 1'b1, 1'b1, 4'b0101})
                    begin failures++; $display("FAIL scanflush_commit: idx=%0d vel=%0d gate=%b retrig=%b mask=%b required 0/77/1/1/0101", voice_idx, voice_velocity, voice_gate, voice_retrig, active_mask); end
            end
            if (s == 8 || s == 10) begin
                checks++;
                if ({voice_idx, voice_note, voice_gate, voice_retrig} !== {2'(s == 8 ? 0 : 2), 7'(s == 8 ? 60 : 64), 2'b00})
                    begin failures++; $display("FAIL scanflush_release_c%0d: idx=%0d note=%0d gate=%b retrig=%b", s, voice_idx, voice_note, voice_gate, voice_retrig); end
            end
            if (s == 1) ev_valid = 1'b0;
            if (s == 2) all_off = 1'b1;
            if (s == 3) all_off = 1'b0;
        end
        checks++; if (active_mask !== 4'b0000) begin failures++; $display("FAIL scanflush_mask: got %b required 0000", active_mask); end
    endtask

    task automatic test_flush_repeat();
        apply_reset();
        run_event(1, 50, 10);
        run_event(1, 51, 11);
        all_off = 1'b1;
        @(negedge clk);
        all_off = 1'b0;
        for (int s = 0; s <= 2 * N + 1; s++) begin
            if (s > 0) @(negedge clk);
            checks++;
            if (ev_ready !== (s == 2 * N + 1)) begin failures++; $display("FAIL reflush_ready_c%0d: got %b required %b", s, ev_ready, s == 2 * N + 1); end
            checks++;
            if (voice_we !== (s == 1 || s == 2)) begin failures++; $display("FAIL reflush_we_c%0d: got %b required %b", s, voice_we, s == 1 || s == 2); end
            if (s == 1) all_off = 1'b1;
            if (s == 2) all_off = 1'b0;
        end
        model_clear();
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        run_event(1, 60, 100);
        run_event(1, 62, 100);
        run_event(1, 64, 100);
        all_off = 1'b1;
        @(negedge clk);
        all_off = 1'b0;
        @(negedge clk);
        checks++; if (voice_we !== 1'b1) begin failures++; $display("FAIL midflush_first_write: got %b required 1", voice_we); end
        rstn = 1'b0;
        #1;
        checks++;
        if ({voice_we, voice_idx, voice_note, voice_velocity, voice_gate, voice_retrig, stolen, dropped, active_mask} !== '0)
            begin failures++; $display("FAIL midflush_reset: we=%b idx=%0d note=%0d gate=%b mask=%b required all 0", voice_we, voice_idx, voice_note, voice_gate, active_mask); end
        checks++; if (ev_ready !== 1'b1) begin failures++; $display("FAIL midflush_ready: got %b required 1", ev_ready); end
        @(negedge clk);
        rstn = 1'b1;
        model_clear();
        run_event(1, 70, 20);
        checks++;
        if ({c_nwe == 1, c_idx, c_mask, c_rdy_after} !== {1'b1, 2'd0, 4'b0001, 1'b1})
            begin failures++; $display("FAIL after_reset_event: nwe=%0d idx=%0d mask=%b ready=%b required 1/0/0001/1", c_nwe, c_idx, c_mask, c_rdy_after); end
    endtask

    task automatic test_random();
        bit on, exp_we;
        int nt, vl;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            on = ($urandom_range(0, 9) < 7);
            nt = $urandom_range(60, 65);
            vl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
            run_event(on, nt, vl);
            checks++;
            if (c_nwe !== int'(e_we)) begin failures++; $display("FAIL rnd%0d_we: got %0d required %0d", n, c_nwe, e_we); end
            checks++;
            if ({c_stolen, c_dropped} !== {e_stolen, e_dropped})
                begin failures++; $display("FAIL rnd%0d_pulses: stolen=%b dropped=%b required %b/%b", n, c_stolen, c_dropped, e_stolen, e_dropped); end
            checks++;
            if (c_mask !== model_mask()) begin failures++; $display("FAIL rnd%0d_mask: got %b required %b", n, c_mask, model_mask()); end
            checks++;
            if ({c_rdy_commit, c_rdy_after} !== 2'b01) begin failures++; $display("FAIL rnd%0d_ready: commit=%b after=%b required 0/1", n, c_rdy_commit, c_rdy_after); end
            if (e_we) begin
                checks++;
                if ({c_idx, c_note, c_vel, c_gate, c_retrig} !== {IW'(e_idx), 7'(e_note), 7'(e_vel), e_gate, e_retrig})
                    begin failures++; $display("FAIL rnd%0d_write: idx=%0d note=%0d vel=%0d gate=%b retrig=%b required %0d/%0d/%0d/%b/%b", n, c_idx, c_note, c_vel, c_gate, c_retrig, e_idx, e_note, e_vel, e_gate, e_retrig); end
            end
            if ($urandom_range(0, 19) == 0) begin
                all_off = 1'b1;
                #1;
                checks++; if (ev_ready !== 1'b0) begin failures++; $display("FAIL rnd%0d_flush_gate: got %b required 0", n, ev_ready); end
                @(negedge clk);
                all_off = 1'b0;
                for (int s = 0; s <= N; s++) begin
                    if (s > 0) @(negedge clk);
                    exp_we = (s >= 1) ? (m_active[(s >= 1) ? s - 1 : 0] != 0) : 1'b0;
                    checks++;
                    if (voice_we !== exp_we) begin failures++; $display("FAIL rnd%0d_flush_we_c%0d: got %b required %b", n, s, voice_we, exp_we); end
                    if (exp_we) begin
                        checks++;
                        if ({voice_idx, voice_note, voice_velocity, voice_gate, voice_retrig} !== {IW'(s - 1), 7'(m_note[s - 1]), 7'(m_vel[s - 1]), 2'b00})
                            begin failures++; $display("FAIL rnd%0d_flush_write_c%0d: idx=%0d note=%0d vel=%0d gate=%b", n, s, voice_idx, voice_note, voice_velocity, voice_gate); end
                    end
                    checks++;
                    if (ev_ready !== (s == N)) begin failures++; $display("FAIL rnd%0d_flush_ready_c%0d: got %b required %b", n, s, ev_ready, s == N); end
                end
                model_clear();
                checks++; if (active_mask !== 4'b0000) begin failures++; $display("FAIL rnd%0d_flush_mask: got %b required 0000", n, active_mask); end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_first_note();
        test_pool_full();
        test_retrigger();
        test_note_off();
        test_vel_zero();
        test_all_off_scan();
        test_flush_repeat();
        test_reset_mid_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
